// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {
    DT_BYTE = 2'b00,
    DT_HALF = 2'b01,
    DT_WORD = 2'b10
  } data_type_e;
  typedef enum logic [2:0] {
    IDLE,
    REQ1,
    WAIT1,
    REQ2,
    WAIT2,
    DONE
  } lsu_state_e;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-enable/write-data alignment and load-data realignment with extension
module lsu_align import lsu_pkg::*; (
  input  logic [1:0]  off,
  input  logic [1:0]  dtype,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  output logic [7:0]  be8,
  output logic [63:0] w64,
  output logic        split,
  output logic [31:0] rdata_ext
);
  logic [3:0]  base_be;
  logic [5:0]  sh;
  logic [31:0] r32;
  // Shift enables and data across a two-word window; the upper word only matters for split accesses
  always_comb begin
    base_be   = dtype == DT_BYTE ? BE_BYTE : dtype == DT_HALF ? BE_HALF : BE_WORD;
    sh        = {off, 3'b000};
    be8       = {4'b0000, base_be} << off;
    split     = |be8[7:4];
    w64       = {32'h0, wdata} << sh;
    r32       = 32'({split ? rdata2 : 32'h0, rdata1} >> sh);
    rdata_ext = dtype == DT_BYTE ? {{24{sign_ext & r32[7]}}, r32[7:0]} :
                dtype == DT_HALF ? {{16{sign_ext & r32[15]}}, r32[15:0]} : r32;
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer with one outstanding bus transaction and misaligned splitting
module lsu_ctrl import lsu_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            data_type_i,
  input  logic                  sign_ext_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  stall_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
  lsu_state_e            state, state_d;
  logic                  we_q, sign_q;
  logic [1:0]            type_q;
  logic [ADDR_WIDTH-1:0] addr_q, word_addr;
  logic [DATA_WIDTH-1:0] wdata_q, rdata1_q, rdata_q;
  logic [7:0]            be8;
  logic [63:0]           w64;
  logic                  split, illegal_q, load_done;
  logic [31:0]           rdata_ext;
  lsu_align u_align (
    .off       (addr_q[1:0]),
    .dtype     (type_q),
    .sign_ext  (sign_q),
    .wdata     (wdata_q),
    .rdata1    (state == WAIT1 ? mem_rdata_i : rdata1_q),
    .rdata2    (mem_rdata_i),
    .be8       (be8),
    .w64       (w64),
    .split     (split),
    .rdata_ext (rdata_ext)
  );
  assign illegal_q   = &type_q;
  assign word_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign load_done   = !we_q && mem_rvalid_i && ((state == WAIT1 && !split) || state == WAIT2);
  assign stall_o     = (state == IDLE && req_i) || state == REQ1 || state == WAIT1 || state == REQ2 || state == WAIT2;
  assign rvalid_o    = state == DONE && !we_q && !illegal_q;
  assign err_o       = state == DONE && illegal_q;
  assign rdata_o     = rdata_q;
  assign mem_addr_o  = word_addr + (state == REQ2 ? ADDR_WIDTH'(4) : '0);
  assign mem_we_o    = mem_req_o && we_q;
  assign mem_be_o    = state == REQ1 ? be8[3:0] : state == REQ2 ? be8[7:4] : 4'b0000;
  assign mem_wdata_o = state == REQ1 ? w64[31:0] : state == REQ2 ? w64[63:32] : '0;
  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  // Request capture, beat-1 read data and the held load result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      sign_q   <= 1'b0;
      type_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata1_q <= '0;
      rdata_q  <= '0;
    end else begin
      if (state == IDLE && req_i) begin
        we_q    <= we_i;
        sign_q  <= sign_ext_i;
        type_q  <= data_type_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (state == WAIT1 && mem_rvalid_i) rdata1_q <= mem_rdata_i;
      if (load_done) rdata_q <= rdata_ext;
    end
  end
  // Next-state logic and bus request
  always_comb begin
    state_d   = state;
    mem_req_o = 1'b0;
    case (state)
      IDLE:  if (req_i) state_d = &data_type_i ? DONE : REQ1;
      REQ1:  begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) state_d = WAIT1;
      end
      WAIT1: if (mem_rvalid_i) state_d = split ? REQ2 : DONE;
      REQ2:  begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) state_d = WAIT2;
      end
      WAIT2: if (mem_rvalid_i) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Sequences load/store requests from the execute stage onto the data-memory bus, using a req/gnt/rvalid handshake with one outstanding transaction. Little-endian. Splits misaligned word and halfword accesses into two word-aligned bus beats. Aligns byte enables and write data, realigns and sign/zero-extends read data, and stalls the pipeline until the access completes. Sits between the decoder/register file and the data TCM/external memory.

Parameters:
DATA_WIDTH, 32, data bus width (only 32 supported)
ADDR_WIDTH, 32, address width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
req_i  in  1  load/store request from EX, held until stall_o drops
we_i  in  1  0 load, 1 store
data_type_i  in  2  00 byte, 01 halfword, 10 word, 11 illegal
sign_ext_i  in  1  sign-extend load result
addr_i  in  ADDR_WIDTH  byte address
wdata_i  in  DATA_WIDTH  store data, LSB-aligned
stall_o  out  1  hold pipeline
rvalid_o  out  1  load result valid, 1-cycle pulse
rdata_o  out  DATA_WIDTH  extended load result
err_o  out  1  illegal data_type, 1-cycle pulse
mem_req_o  out  1  bus request
mem_gnt_i  in  1  bus grant
mem_addr_o  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0)
mem_we_o  out  1  write enable
mem_be_o  out  4  byte enables
mem_wdata_o  out  DATA_WIDTH  aligned write data
mem_rvalid_i  in  1  beat complete (reads and writes); rdata valid
mem_rdata_i  in  DATA_WIDTH  read data

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE. mem_req_o=0, rvalid_o=0, err_o=0, rdata_o=0, all captured registers 0. stall_o is combinational, so in IDLE it equals req_i.
- States:
  - IDLE: on req_i, capture we/type/sign/addr/wdata. Next state is REQ1, or DONE if type==11.
  - REQ1: mem_req_o=1. Advance to WAIT1 on mem_gnt_i.
  - WAIT1: on mem_rvalid_i, store beat-1 rdata. Next state is REQ2 if split, else DONE.
  - REQ2: mem_req_o=1, address +4. Advance to WAIT2 on mem_gnt_i.
  - WAIT2: on mem_rvalid_i, go to DONE.
  - DONE: stall_o=0. rvalid_o=1 for loads, err_o=1 for illegal type. req_i is ignored. Next state IDLE.
- stall_o = (IDLE && req_i) || state in {REQ1, WAIT1, REQ2, WAIT2}.
- off = addr[1:0]. base_be: 0001 (byte), 0011 (half), 1111 (word). be8 = base_be << off (8 bits).
- Beat 1 drives mem_be_o = be8[3:0]. Beat 2 drives be8[7:4].
- split = (be8[7:4] != 0); true for half with off=3 and word with off!=0.
- Write data: w64 = wdata << (8*off). Beat 1 drives w64[31:0], beat 2 drives w64[63:32].
- Addresses: beat 1 uses {addr[31:2], 00}; beat 2 adds 4. Wrap at 0xFFFFFFFC goes to 0x00000000.
- Read data:
  - r64 = {beat2, beat1} >> (8*off). Beat2 is treated as 0 when not split.
  - Extend the low 8 or 16 bits per type and sign_ext. Word passes through.
  - rdata_o is registered on entry to DONE and holds until the next load completes.
- While mem_req_o=1, mem_addr_o, mem_be_o, mem_we_o and mem_wdata_o stay stable until mem_gnt_i. Grant in the same cycle as the request is legal.
- Outside REQ states, mem_req_o=0. mem_be_o and mem_wdata_o are 0 when mem_req_o=0.
- mem_rvalid_i is ignored outside WAIT1/WAIT2, including late responses after a reset.
- Minimum latency of an aligned access: IDLE, REQ1 (gnt), WAIT1 (rvalid), DONE, so stall_o is high for 3 cycles. A split access adds 2 cycles.
- Reset mid-operation aborts at the next edge; no completion pulse is produced.

Decomposition:
- Package lsu_pkg holds:
  - data_type_e enum: DT_BYTE=00, DT_HALF=01, DT_WORD=10.
  - lsu_state_e enum: IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE.
  - Base byte-enable constants.
- Sub-module lsu_align (combinational):
  - Inputs: off, type, sign_ext, wdata, beat1/beat2 rdata.
  - Outputs: be8, w64, split, extended rdata.
- lsu_ctrl holds the FSM and registers only.

Test Plan:
- Aligned word load at 0x100, gnt with req, rdata 0xDEADBEEF the next cycle -> one beat at addr 0x100, be 1111; rdata_o=0xDEADBEEF with rvalid_o pulse; stall_o high 3 cycles.
- Byte load at 0x103, rdata 0x80123456 -> be 1000. Signed gives rdata_o=0xFFFFFF80; unsigned gives 0x00000080.
- Word store at 0x102, wdata 0x11223344 -> beat 1 addr 0x100, be 1100, data 0x33440000. Beat 2 addr 0x104, be 0011, data 0x00001122. rvalid_o stays 0.
- Signed half load at 0x207, beat 1 rdata 0xAB000000, beat 2 rdata 0x000000CD -> addrs 0x204/0x208, be 1000/0001, rdata_o=0xFFFFCDAB.
- gnt delayed 3 cycles -> mem_req_o, addr, be, wdata held stable for 4 cycles; stall_o high throughout.
- Reset in WAIT1, then late rvalid -> IDLE next cycle with mem_req_o=0; rvalid ignored.
- data_type 11 -> no mem_req_o; err_o pulse one cycle after req; stall_o high 1 cycle.
